// File: rtl/eth_frame_gen.sv
// Ethernet frame generator: MAC header, length field and incrementing payload
// per calculator slice, with an inter-frame gap between frames.
module eth_frame_gen #(
  parameter logic [47:0] DEST_MAC   = 48'hDA0102030405,
  parameter logic [47:0] SRC_MAC    = 48'h5A0102030405,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] number_of_bytes,
  input  logic [15:0] payload_len,
  input  logic        remain_zero,
  output logic        payload_en,
  output logic        payload_cal,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_count
);

  localparam int IW = $clog2(IFG_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    IFG
  } state_t;

  state_t        state;
  logic [15:0]   frame_len;
  logic [15:0]   pay_idx;
  logic [3:0]    hdr_idx;
  logic [IW-1:0] ifg_cnt;
  logic          last_frame;

  logic          pay_last;
  logic [111:0]  hdr_vec;
  logic [111:0]  hdr_sh;
  logic [7:0]    hdr_byte;

  assign pay_last = (pay_idx == frame_len - 16'd1);

  // Header bytes go out MSB first, so shift the selected byte to the top.
  assign hdr_vec  = {DEST_MAC, SRC_MAC, frame_len};
  assign hdr_sh   = hdr_vec << {hdr_idx, 3'b000};
  assign hdr_byte = hdr_sh[111:104];

  assign m_axis_tvalid = (state == HDR) || (state == PAY);
  assign m_axis_tlast  = (state == PAY) && pay_last;
  assign busy          = (state != IDLE);

  always_comb begin
    m_axis_tdata = 8'h00;
    unique case (1'b1)
      state == HDR: m_axis_tdata = hdr_byte;
      state == PAY: m_axis_tdata = pay_idx[7:0];
      default:      m_axis_tdata = 8'h00;
    endcase
  end

  assign payload_en  = (state == IDLE) && start &&
                       (number_of_bytes != 16'd0);
  assign payload_cal = (state == PAY) && m_axis_tready && pay_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_len   <= 16'd0;
      pay_idx     <= 16'd0;
      hdr_idx     <= 4'd0;
      ifg_cnt     <= '0;
      last_frame  <= 1'b0;
      done        <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (payload_en) begin
            state       <= HDR;
            hdr_idx     <= 4'd0;
            frame_count <= 16'd0;
          end
        end
        HDR: begin
          // The calculator output settles after the load/advance edge,
          // so latch it while the first header byte is on the bus.
          if (hdr_idx == 4'd0) begin
            frame_len <= (payload_len == 16'd0) ? 16'd1 : payload_len;
          end
          if (m_axis_tready) begin
            if (hdr_idx == 4'd13) begin
              state   <= PAY;
              pay_idx <= 16'd0;
            end else begin
              hdr_idx <= hdr_idx + 4'd1;
            end
          end
        end
        PAY: begin
          if (m_axis_tready) begin
            if (pay_last) begin
              frame_count <= frame_count + 16'd1;
              last_frame  <= remain_zero;
              ifg_cnt     <= '0;
              if (IFG_CYCLES != 0) begin
                state <= IFG;
              end else if (remain_zero) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state   <= HDR;
                hdr_idx <= 4'd0;
              end
            end else begin
              pay_idx <= pay_idx + 16'd1;
            end
          end
        end
        IFG: begin
          if (ifg_cnt == IW'(IFG_CYCLES - 1)) begin
            if (last_frame) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state   <= HDR;
              hdr_idx <= 4'd0;
            end
          end else begin
            ifg_cnt <= ifg_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
